// File: rtl/counter_sequencer.sv
// counter_sequencer: run/abort counter FSM that reports TICK/HALF/DONE/ABORT events through a small FIFO
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  input  logic             tick_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] EV_TICK = 2'd0, EV_HALF = 2'd1, EV_DONE = 2'd2, EV_ABORT = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, ABORTING, FLUSH} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, limit_q, limit_d, count_inc, push_cnt;
  logic tick_q, tick_d, done_q, done_d, push, pop, full, drained, is_half;
  logic [1:0] push_code;
  logic [WIDTH:0] inc_w, half_w;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] occ_q;
  logic [WIDTH+1:0] mem_q [DEPTH];
  assign inc_w = {1'b0, count_q} + 1'b1;
  assign half_w = ({1'b0, limit_q} + 1'b1) >> 1;
  assign count_inc = inc_w[WIDTH-1:0];
  assign is_half = inc_w == half_w;
  assign full = occ_q == (AW+1)'(DEPTH);
  assign pop = evt_valid & evt_ready;
  // a pop in the same cycle counts toward draining, so FLUSH exits as the last entry leaves
  assign drained = (occ_q == '0) || (occ_q == (AW+1)'(1) && pop);
  assign evt_valid = occ_q != '0;
  assign {evt_code, evt_count} = mem_q[rd_q];
  assign count = count_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    tick_d = tick_q;
    push = 1'b0;
    push_code = EV_TICK;
    push_cnt = count_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        count_d = '0;
        limit_d = limit;
        tick_d = tick_en;
        state_d = RUN;
      end
      RUN: if (abort) state_d = ABORTING;
      else if (!full) begin
        if (count_q == limit_q) begin
          count_d = '0;
          push = 1'b1;
          push_code = EV_DONE;
          push_cnt = limit_q;
          state_d = FLUSH;
        end else begin
          count_d = count_inc;
          push = is_half | tick_q;
          push_code = is_half ? EV_HALF : EV_TICK;
          push_cnt = count_inc;
        end
      end
      ABORTING: if (!full) begin
        push = 1'b1;
        push_code = EV_ABORT;
        state_d = FLUSH;
      end
      FLUSH: if (drained) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      tick_q <= tick_d;
      done_q <= done_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= {push_code, push_cnt};
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed checks of counting, events, stall, abort, limit=0 and reset
module tb_counter_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, tick_en = 1'b0, evt_ready = 1'b0;
  logic [3:0] limit = '0, count, evt_count;
  logic busy, done, evt_valid;
  logic [1:0] evt_code;
  int total = 0, bad = 0;
  int got_code[$], got_cnt[$], exp_code[$], exp_cnt[$];
  counter_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .limit(limit), .tick_en(tick_en),
    .count(count), .busy(busy), .done(done), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_count(evt_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && evt_valid && evt_ready) begin
    got_code.push_back(int'(evt_code));
    got_cnt.push_back(int'(evt_count));
  end
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic add_exp(input int c, input int v);
    exp_code.push_back(c);
    exp_cnt.push_back(v);
  endtask
  task automatic check_events(input string tag);
    check({tag, "_n"}, got_code.size(), exp_code.size());
    for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
      check($sformatf("%s_code%0d", tag, i), got_code[i], exp_code[i]);
      check($sformatf("%s_cnt%0d", tag, i), got_cnt[i], exp_cnt[i]);
    end
    got_code.delete(); got_cnt.delete(); exp_code.delete(); exp_cnt.delete();
  endtask
  task automatic pulse_start(input int lim, input logic te);
    limit = 4'(lim);
    tick_en = te;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    cyc(1);
    check({tag, "_done_once"}, int'(done), 0);
  endtask
  task automatic wait_count(input string tag, input int val, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (count == 4'(val)) begin
        seen = 1;
        break;
      end
      cyc(1);
    end
    check({tag, "_reach"}, seen, 1);
  endtask
  initial begin
    cyc(2);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0;
    cyc(1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(evt_valid), 0);
    // full run with consumer always ready
    evt_ready = 1'b1;
    pulse_start(15, 1'b1);
    check("run_busy", int'(busy), 1);
    wait_done("full", 60);
    for (int i = 1; i <= 15; i++) add_exp(i == 8 ? 1 : 0, i);
    add_exp(2, 15);
    check_events("full");
    check("full_count", int'(count), 0);
    // back-pressure: stall at 4 with buffer full, then drain
    evt_ready = 1'b0;
    pulse_start(15, 1'b1);
    cyc(10);
    check("stall_count", int'(count), 4);
    check("stall_valid", int'(evt_valid), 1);
    check("stall_head_code", int'(evt_code), 0);
    check("stall_head_cnt", int'(evt_count), 1);
    cyc(3);
    check("stall_hold", int'(count), 4);
    check("stall_head_stable", int'(evt_count), 1);
    evt_ready = 1'b1;
    wait_done("drain", 60);
    for (int i = 1; i <= 15; i++) add_exp(i == 8 ? 1 : 0, i);
    add_exp(2, 15);
    check_events("drain");
    // ticks off: only HALF and DONE
    pulse_start(9, 1'b0);
    wait_done("notick", 40);
    add_exp(1, 5);
    add_exp(2, 9);
    check_events("notick");
    check("notick_count", int'(count), 0);
    // abort while the buffer is full
    evt_ready = 1'b0;
    pulse_start(15, 1'b1);
    wait_count("abort_pre", 4, 20);
    cyc(2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(3);
    check("abort_count_hold", int'(count), 4);
    check("abort_busy", int'(busy), 1);
    check("abort_head_cnt", int'(evt_count), 1);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    cyc(2);
    check("abort_head_after_pop", int'(evt_count), 2);
    evt_ready = 1'b1;
    wait_done("abort", 20);
    for (int i = 1; i <= 4; i++) add_exp(0, i);
    add_exp(3, 4);
    check_events("abort");
    check("idle_count_hold", int'(count), 4);
    // limit 0 with start ignored during FLUSH
    evt_ready = 1'b0;
    pulse_start(0, 1'b1);
    cyc(2);
    pulse_start(5, 1'b1);
    cyc(1);
    check("lim0_busy", int'(busy), 1);
    check("lim0_count", int'(count), 0);
    check("lim0_head_code", int'(evt_code), 2);
    check("lim0_head_cnt", int'(evt_count), 0);
    evt_ready = 1'b1;
    wait_done("lim0", 10);
    add_exp(2, 0);
    check_events("lim0");
    cyc(2);
    check("lim0_no_restart", int'(busy), 0);
    // reset mid-run with two events buffered
    evt_ready = 1'b0;
    pulse_start(15, 1'b1);
    wait_count("rst_pre", 2, 10);
    check("rst_pre_valid", int'(evt_valid), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_valid", int'(evt_valid), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    cyc(1);
    check("midrst_done2", int'(done), 0);
    check("midrst_valid2", int'(evt_valid), 0);
    check("midrst_pops", got_code.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
